// File: rtl/b_prog_loader_if.sv
// rtl/b_prog_loader_if.sv - loader control, byte stream and memory-write signal bundle
interface b_prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_reset;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_we, busy, done, error, cpu_reset
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_we, busy, done, error, cpu_reset
  );
endinterface

// File: rtl/b_prog_loader.sv
// rtl/b_prog_loader.sv - streams a length-prefixed program image into word memory, then releases cpu_reset
// Optional B_PROG_LOADER_CHECKSUM_EN: a trailing XOR-of-data-bytes check byte is required.
module b_prog_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input logic            clk,
  input logic            reset,
  b_prog_loader_if.slave bus
);
  localparam int NB     = WORD_W / 8;
  localparam int BCNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCNT_W-1:0] LAST_B = BCNT_W'(NB - 1);
  localparam logic [64:0]       DEPTH  = 65'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE,
`ifdef B_PROG_LOADER_CHECKSUM_EN
    S_FIN,
`endif
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       n;
  logic [16:0]       idx;
  logic [BCNT_W-1:0] bcnt;
  logic [WORD_W-1:0] word;
`ifdef B_PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic              xfer;
  logic [15:0]       n_full;
  logic [16:0]       idx_next;
  logic [WORD_W-1:0] word_next;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign n_full    = {n[15:8], bus.in_data};
  assign idx_next  = idx + 17'd1;
  assign word_next = (word << 8) | WORD_W'(bus.in_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
      bus.cpu_reset <= 1'b1;
      idx           <= '0;
      n             <= '0;
      bcnt          <= '0;
      word          <= '0;
`ifdef B_PROG_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state         <= S_LEN_HI;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b1;
          bus.done      <= 1'b0;
          bus.error     <= 1'b0;
          bus.cpu_reset <= 1'b1;
        end
        S_LEN_HI: if (xfer) begin
          n[15:8] <= bus.in_data;
          state   <= S_LEN_LO;
        end
        S_LEN_LO: if (xfer) begin
          n    <= n_full;
          idx  <= '0;
          bcnt <= '0;
`ifdef B_PROG_LOADER_CHECKSUM_EN
          csum <= '0;
`endif
          if (65'(n_full) > DEPTH) begin
            // image would not fit: abort before touching memory
            state         <= S_DONE;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.error     <= 1'b1;
          end else if (n_full == 16'd0) begin
`ifdef B_PROG_LOADER_CHECKSUM_EN
            state         <= S_FIN;
`else
            state         <= S_DONE;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.cpu_reset <= 1'b0;
`endif
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (xfer) begin
`ifdef B_PROG_LOADER_CHECKSUM_EN
          csum <= csum ^ bus.in_data;
`endif
          if (bcnt == LAST_B) begin
            bcnt          <= '0;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'(idx);
            bus.mem_wdata <= word_next;
            bus.in_ready  <= 1'b0;
            state         <= S_WRITE;
          end else begin
            word <= word_next;
            bcnt <= bcnt + 1'b1;
          end
        end
        S_WRITE: begin
          idx <= idx_next;
          if (idx_next == 17'(n)) begin
`ifdef B_PROG_LOADER_CHECKSUM_EN
            state         <= S_FIN;
            bus.in_ready  <= 1'b1;
`else
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.cpu_reset <= 1'b0;
`endif
          end else begin
            state        <= S_DATA;
            bus.in_ready <= 1'b1;
          end
        end
`ifdef B_PROG_LOADER_CHECKSUM_EN
        S_FIN: if (xfer) begin
          state         <= S_DONE;
          bus.in_ready  <= 1'b0;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b1;
          bus.error     <= (bus.in_data != csum);
          bus.cpu_reset <= (bus.in_data != csum);
        end
`endif
        S_DONE: state <= S_IDLE;
        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_b_prog_loader.sv
// tb/tb_b_prog_loader.sv - randomized and directed load checks against a stream-format reference model
module tb_b_prog_loader;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;
  localparam int NB     = WORD_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W+WORD_W-1:0] wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  b_prog_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();
  b_prog_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int         total = 0;
  int         bad   = 0;
  wr_t        wq[$];
  wr_t        exp_wq[$];
  logic [7:0] stream[$];
  int         exp_n;
  logic       exp_err;
  logic       exp_lenerr;

  always @(negedge clk) if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: parse the byte stream as count + big-endian words (+ optional XOR byte).
  task automatic model();
    logic [7:0]        x;
    logic [WORD_W-1:0] w;
    exp_wq.delete();
    exp_n      = int'({stream[0], stream[1]});
    exp_lenerr = (exp_n > DEPTH);
    exp_err    = exp_lenerr;
    x          = 8'h00;
    if (!exp_lenerr) begin
      for (int k = 0; k < exp_n; k++) begin
        w = '0;
        for (int b = 0; b < NB; b++) begin
          w = (w << 8) | WORD_W'(stream[2 + k*NB + b]);
          x = x ^ stream[2 + k*NB + b];
        end
        exp_wq.push_back({ADDR_W'(k), w});
      end
`ifdef B_PROG_LOADER_CHECKSUM_EN
      if (stream.size() <= 2 + exp_n*NB) exp_err = 1'b1;
      else if (stream[2 + exp_n*NB] != x) exp_err = 1'b1;
`endif
    end
  endtask

  function automatic logic is_last(input int k);
    return !exp_lenerr && k >= 2 && k < 2 + exp_n*NB && ((k - 2) % NB) == NB - 1;
  endfunction

  task automatic add_csum();
`ifdef B_PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int k = 2; k < stream.size(); k++) x = x ^ stream[k];
    stream.push_back(x);
`endif
  endtask

  task automatic build(input int n);
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int k = 0; k < n*NB; k++) stream.push_back(8'($urandom));
    add_csum();
  endtask

  task automatic do_start(input string name);
    wq.delete();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk1({name, ":start_busy"},      bus.busy,      1'b1);
    chk1({name, ":start_cpu_reset"}, bus.cpu_reset, 1'b1);
    chk1({name, ":start_done"},      bus.done,      1'b0);
    chk1({name, ":start_error"},     bus.error,     1'b0);
    chk1({name, ":start_in_ready"},  bus.in_ready,  1'b1);
  endtask

  // mode 0: in_valid always high, 1: toggles every cycle, 2: random ~70%
  task automatic run_load(input int mode, input string name);
    int   idx, cyc, budget;
    logic exp_we, xfer, got_done;
    model();
    do_start(name);
    idx = 0; cyc = 0; exp_we = 1'b0; got_done = 1'b0;
    budget = 60 + 4*stream.size() + 4*exp_n;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      chk1({name, ":mem_we"}, bus.mem_we, exp_we);
      if (bus.mem_we === 1'b1) chk1({name, ":ready_in_write"}, bus.in_ready, 1'b0);
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (idx < stream.size()) begin
        bus.in_data  = stream[idx];
        bus.in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 9) < 7);
      end else begin
        bus.in_data  = 8'($urandom);
        bus.in_valid = 1'($urandom);
      end
      bus.start = (idx > 0) && ($urandom_range(0, 7) == 0);
      xfer = bus.in_valid && bus.in_ready;
      @(posedge clk);
      exp_we = xfer && is_last(idx);
      if (xfer) idx++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk1({name, ":done_reached"}, got_done, 1'b1);
    chkw({name, ":bytes_taken"}, 64'(idx), 64'(stream.size()));
    chk1({name, ":done"},      bus.done,      1'b1);
    chk1({name, ":busy"},      bus.busy,      1'b0);
    chk1({name, ":error"},     bus.error,     exp_err);
    chk1({name, ":cpu_reset"}, bus.cpu_reset, exp_err);
    chkw({name, ":n_writes"}, 64'(wq.size()), 64'(exp_wq.size()));
    for (int i = 0; i < wq.size() && i < exp_wq.size(); i++)
      chkw({name, ":write"}, 64'(wq[i]), 64'(exp_wq[i]));
    // start while in DONE must not begin a new load
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk1({name, ":start_in_done_busy"}, bus.busy, 1'b0);
    chk1({name, ":start_in_done_done"}, bus.done, 1'b1);
  endtask

  initial begin
    int   idx, cyc, extra;
    logic seen, xfer;
    reset = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst:in_ready",  bus.in_ready,  1'b0);
    chk1("rst:mem_we",    bus.mem_we,    1'b0);
    chkw("rst:mem_addr",  64'(bus.mem_addr),  64'(0));
    chkw("rst:mem_wdata", 64'(bus.mem_wdata), 64'(0));
    chk1("rst:busy",      bus.busy,      1'b0);
    chk1("rst:done",      bus.done,      1'b0);
    chk1("rst:error",     bus.error,     1'b0);
    chk1("rst:cpu_reset", bus.cpu_reset, 1'b1);
    reset = 1'b0;

    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
    add_csum();
    run_load(0, "two_words");
    chkw("two_words:lit0", 64'(wq[0]), 64'({8'h00, 32'hDEADBEEF}));
    chkw("two_words:lit1", 64'(wq[1]), 64'({8'h01, 32'h0000002A}));
    chk1("two_words:lit_cpu_reset", bus.cpu_reset, 1'b0);

    stream = '{8'h00, 8'h00};
    add_csum();
    run_load(2, "zero_len");
    chk1("zero_len:lit_error", bus.error, 1'b0);

    stream = '{8'h01, 8'h01};
    run_load(0, "too_long");
    chk1("too_long:lit_error", bus.error, 1'b1);
    chk1("too_long:lit_cpu_reset", bus.cpu_reset, 1'b1);

    build(1);
    run_load(1, "toggle_valid");
    build(DEPTH);
    run_load(0, "full_depth");
    for (int t = 0; t < 8; t++) begin
      build($urandom_range(1, 6));
      run_load(2, "random");
    end
    stream = '{8'h00, 8'h00};
    begin
      int n;
      n = $urandom_range(DEPTH + 2, 65535);
      stream[0] = 8'(n >> 8);
      stream[1] = 8'(n);
    end
    run_load(2, "random_too_long");

`ifdef B_PROG_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_load(0, "csum_bad");
    chk1("csum_bad:lit_error", bus.error, 1'b1);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load(0, "csum_good");
    chk1("csum_good:lit_error", bus.error, 1'b0);
    chk1("csum_good:lit_cpu_reset", bus.cpu_reset, 1'b0);
`endif

    // reset right after the first of two words has been written
    build(2);
    model();
    do_start("mid_reset");
    idx = 0; cyc = 0; seen = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stream[idx];
      xfer = bus.in_ready;
      @(posedge clk);
      if (xfer) idx++;
    end
    chk1("mid_reset:first_write_seen", seen, 1'b1);
    chkw("mid_reset:first_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_wq[0]));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk1("mid_reset:busy",      bus.busy,      1'b0);
    chk1("mid_reset:cpu_reset", bus.cpu_reset, 1'b1);
    chk1("mid_reset:in_ready",  bus.in_ready,  1'b0);
    chk1("mid_reset:done",      bus.done,      1'b0);
    extra = 0;
    repeat (12) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      if (bus.mem_we === 1'b1) extra++;
    end
    bus.in_valid = 1'b0;
    chkw("mid_reset:no_more_writes", 64'(extra), 64'(0));

    build(3);
    run_load(2, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/b_prog_loader.md
B_PROG_LOADER -- requirements
Module: b_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the target memory (depth 2**ADDR_W words).
REQ-002 Parameter WORD_W, default 32, memory word width; SHALL be a multiple of 8.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a load when in IDLE, ignored otherwise.
REQ-006 in_valid  in  1  byte-stream source has a byte on in_data.
REQ-007 in_data  in  8  stream byte.
REQ-008 in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at posedge clk.
REQ-009 mem_addr  out  ADDR_W  word address of the current write.
REQ-010 mem_wdata  out  WORD_W  assembled word.
REQ-011 mem_we  out  1  one-cycle write strobe.
REQ-012 busy  out  1  load in progress.
REQ-013 done  out  1  load finished; sticky until next accepted start or reset.
REQ-014 error  out  1  load aborted or corrupted; sticky like done.
REQ-015 cpu_reset  out  1  holds the CPU in reset; high except after a successful load.

Function
REQ-016 Stream format: 2-byte big-endian word count N, then N words of WORD_W/8 bytes each, most significant byte first.
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, FIN (FIN exists only with the checksum macro), DONE.
REQ-018 IDLE -> LEN_HI on start; done and error clear and busy rises in the same edge.
REQ-019 in_ready is high only in LEN_HI, LEN_LO, DATA, and FIN; it is low in IDLE, WRITE, and DONE.
REQ-020 LEN_HI -> LEN_LO on a transfer; LEN_LO -> DATA on a transfer, with word index cleared to 0.
REQ-021 In LEN_LO, a transfer with N == 0 goes to DONE (or to FIN with the checksum macro); no writes occur.
REQ-022 In LEN_LO, a transfer with N > 2**ADDR_W goes to DONE with error=1; no writes occur.
REQ-023 In DATA, bytes shift into a word register; after the last byte of a word, next state is WRITE.
REQ-024 WRITE lasts exactly one cycle: mem_we=1, mem_addr=index, mem_wdata=assembled word; then index increments.
REQ-025 After WRITE, if index == N the FSM goes to DONE (or FIN), otherwise back to DATA.
REQ-026 Latency: the first mem_we occurs one cycle after the word's last byte transfer; sustained throughput is WORD_W/8 + 1 cycles per word.
REQ-027 in_valid low stalls the FSM in place; there is no timeout.
REQ-028 DONE sets done=1 and busy=0; if error=0, cpu_reset falls to 0 in the same edge; DONE -> IDLE on the next cycle.
REQ-029 start asserted while busy is ignored; start in DONE is ignored until the FSM reaches IDLE.
REQ-030 mem_we is 0 in every state other than WRITE.

Reset
REQ-031 On reset: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_reset=1, index=0, N=0.
REQ-032 Reset during a load abandons it; words already written remain in memory and no further write occurs.
REQ-033 A start accepted after a successful load raises cpu_reset to 1 again until the new load succeeds.

Configuration
REQ-034 Macro B_PROG_LOADER_CHECKSUM_EN defined: after the last word, FIN accepts one byte that SHALL equal the XOR of all data bytes; on mismatch error=1 and cpu_reset stays 1; then -> DONE.
REQ-035 Macro undefined: the FIN state, the checksum register, and the trailing byte do not exist; transitions go directly to DONE.

Verification
REQ-036 reset, start, stream 00 02 DE AD BE EF 00 00 00 2A -> writes [0]=DEADBEEF, [1]=0000002A; done=1; cpu_reset=0.
REQ-037 start, stream 00 00 -> no mem_we; done=1; error=0 (with the macro, the trailing checksum byte 00 is also required).
REQ-038 ADDR_W=8, stream 01 01 -> no writes; done=1; error=1; cpu_reset=1.
REQ-039 in_valid toggled every other cycle on a 1-word load -> the same single write; in_ready=0 during WRITE.
REQ-040 reset asserted after 1 of 2 words is written -> IDLE, busy=0, cpu_reset=1; no second write.
REQ-041 Macro defined, stream 00 01 12 34 56 78 then byte 09 -> done=1, error=1; then byte 08 -> error=0, cpu_reset=0.
